// File: rtl/rformat_exec_if.sv
// =============================================================================
//  Module   : rformat_exec_if
//  Purpose  : Bundles the instruction-issue handshake, the single-port register
//             file bus and the completion status of the R-format executor.
//  Modports : master - the executor (answers issue, drives the regfile port,
//                      reports completion)
//             slave  - the environment (offers instructions, owns the regfile
//                      storage, consumes completion status)
//  Signals  : in_valid/in_ready/instr      instruction issue handshake
//             rf_address/rf_en_write/
//             rf_idata/rf_data             regfile port (rf_data is a
//                                          registered read, one cycle late)
//             done/result/err/ovf          completion pulse and status
//  Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

interface rformat_exec_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [4:0]  rf_address;
  logic        rf_en_write;
  logic [31:0] rf_idata;
  logic [31:0] rf_data;
  logic        done;
  logic [31:0] result;
  logic        err;
  logic        ovf;

  modport master (
    input  in_valid, instr, rf_data,
    output in_ready, rf_address, rf_en_write, rf_idata, done, result, err, ovf
  );

  modport slave (
    output in_valid, instr, rf_data,
    input  in_ready, rf_address, rf_en_write, rf_idata, done, result, err, ovf
  );
endinterface

`default_nettype wire

// File: rtl/rformat_exec.sv
// =============================================================================
//  Module   : rformat_exec
//  Purpose  : Executes one MIPS R-format instruction at a time against a
//             single-port register file: read rs, read rt, compute, write rd,
//             then pulse done with result/err/ovf.
//  Ports    : clock  - system clock, rising edge
//             reset  - asynchronous active-high reset
//             bus    - rformat_exec_if.master (issue, regfile, status)
//  Params   : SUPPRESS_R0 - drop writes to register 0 (status still reported)
//             OVF_TRAP    - signed add/sub overflow suppresses the write
//  Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module rformat_exec #(
  parameter bit SUPPRESS_R0 = 1'b1,
  parameter bit OVF_TRAP    = 1'b1
) (
  input  wire logic      clock,
  input  wire logic      reset,
  rformat_exec_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_RS   = 3'd1,
    S_RD_RT   = 3'd2,
    S_WAIT_RT = 3'd3,
    S_WRITE   = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam logic [5:0] c_F_SLL  = 6'h00;
  localparam logic [5:0] c_F_SRL  = 6'h02;
  localparam logic [5:0] c_F_SRA  = 6'h03;
  localparam logic [5:0] c_F_ADD  = 6'h20;
  localparam logic [5:0] c_F_ADDU = 6'h21;
  localparam logic [5:0] c_F_SUB  = 6'h22;
  localparam logic [5:0] c_F_SUBU = 6'h23;
  localparam logic [5:0] c_F_AND  = 6'h24;
  localparam logic [5:0] c_F_OR   = 6'h25;
  localparam logic [5:0] c_F_XOR  = 6'h26;
  localparam logic [5:0] c_F_NOR  = 6'h27;
  localparam logic [5:0] c_F_SLT  = 6'h2A;
  localparam logic [5:0] c_F_SLTU = 6'h2B;

  state_t      r_state;
  logic        r_ready;
  logic [4:0]  r_addr;
  logic        r_we;
  logic [31:0] r_wdata;
  logic        r_done;
  logic [31:0] r_result;
  logic        r_err;
  logic        r_ovf;
  logic        r_ovf_pend;
  logic [31:0] r_op_a;
  logic [4:0]  r_rt;
  logic [4:0]  r_rd;
  logic [4:0]  r_shamt;
  logic [5:0]  r_funct;

  logic        w_accept;
  logic        w_legal;
  logic [31:0] w_b;
  logic [31:0] w_sum;
  logic [31:0] w_diff;
  logic [31:0] w_alu;
  logic        w_ovf;
  logic        w_wen;

  assign w_accept = bus.in_valid && r_ready;

  // Legal means opcode 0 and one of the implemented funct codes.
  always_comb begin
    w_legal = 1'b0;
    if (bus.instr[31:26] == 6'd0) begin
      case (bus.instr[5:0])
        c_F_SLL, c_F_SRL, c_F_SRA, c_F_ADD, c_F_ADDU, c_F_SUB, c_F_SUBU,
        c_F_AND, c_F_OR, c_F_XOR, c_F_NOR, c_F_SLT, c_F_SLTU: w_legal = 1'b1;
        default:                                              w_legal = 1'b0;
      endcase
    end
  end

  // R[rt] arrives on rf_data during WAIT_RT; it feeds the ALU directly on the
  // edge that leaves WAIT_RT, so the write data is already registered when
  // WRITE begins and no separate op_b register is needed.
  assign w_b    = bus.rf_data;
  assign w_sum  = r_op_a + w_b;
  assign w_diff = r_op_a - w_b;

  always_comb begin
    w_alu = 32'd0;
    w_ovf = 1'b0;
    case (r_funct)
      c_F_SLL:  w_alu = w_b << r_shamt;
      c_F_SRL:  w_alu = w_b >> r_shamt;
      c_F_SRA:  w_alu = 32'($signed(w_b) >>> r_shamt);
      c_F_ADD: begin
        w_alu = w_sum;
        w_ovf = (r_op_a[31] == w_b[31]) && (w_sum[31] != r_op_a[31]);
      end
      c_F_ADDU: w_alu = w_sum;
      c_F_SUB: begin
        w_alu = w_diff;
        w_ovf = (r_op_a[31] != w_b[31]) && (w_diff[31] != r_op_a[31]);
      end
      c_F_SUBU: w_alu = w_diff;
      c_F_AND:  w_alu = r_op_a & w_b;
      c_F_OR:   w_alu = r_op_a | w_b;
      c_F_XOR:  w_alu = r_op_a ^ w_b;
      c_F_NOR:  w_alu = ~(r_op_a | w_b);
      c_F_SLT:  w_alu = {31'd0, ($signed(r_op_a) < $signed(w_b))};
      c_F_SLTU: w_alu = {31'd0, (r_op_a < w_b)};
      default:  w_alu = 32'd0;
    endcase
  end

  assign w_wen = !(SUPPRESS_R0 && (r_rd == 5'd0)) && !(OVF_TRAP && w_ovf);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_ready    <= 1'b1;
      r_addr     <= 5'd0;
      r_we       <= 1'b0;
      r_wdata    <= 32'd0;
      r_done     <= 1'b0;
      r_result   <= 32'd0;
      r_err      <= 1'b0;
      r_ovf      <= 1'b0;
      r_ovf_pend <= 1'b0;
      r_op_a     <= 32'd0;
      r_rt       <= 5'd0;
      r_rd       <= 5'd0;
      r_shamt    <= 5'd0;
      r_funct    <= 6'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_ready <= 1'b0;
            r_rt    <= bus.instr[20:16];
            r_rd    <= bus.instr[15:11];
            r_shamt <= bus.instr[10:6];
            r_funct <= bus.instr[5:0];
            if (w_legal) begin
              r_addr  <= bus.instr[25:21];
              r_state <= S_RD_RS;
            end else begin
              // Unsupported: report immediately, never touch the regfile.
              r_done   <= 1'b1;
              r_err    <= 1'b1;
              r_ovf    <= 1'b0;
              r_result <= 32'd0;
              r_state  <= S_DONE;
            end
          end
        end
        S_RD_RS: begin
          r_addr  <= r_rt;
          r_state <= S_RD_RT;
        end
        S_RD_RT: begin
          r_op_a  <= bus.rf_data;
          r_state <= S_WAIT_RT;
        end
        S_WAIT_RT: begin
          r_addr     <= r_rd;
          r_wdata    <= w_alu;
          r_we       <= w_wen;
          r_ovf_pend <= w_ovf;
          r_state    <= S_WRITE;
        end
        S_WRITE: begin
          r_addr   <= 5'd0;
          r_we     <= 1'b0;
          r_wdata  <= 32'd0;
          r_done   <= 1'b1;
          r_result <= r_wdata;
          r_err    <= 1'b0;
          r_ovf    <= r_ovf_pend;
          r_state  <= S_DONE;
        end
        S_DONE: begin
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_addr  <= 5'd0;
          r_we    <= 1'b0;
          r_wdata <= 32'd0;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready    = r_ready;
  assign bus.rf_address  = r_addr;
  // Gated with reset so a write in flight is cancelled the instant reset rises.
  assign bus.rf_en_write = r_we && !reset;
  assign bus.rf_idata    = r_wdata;
  assign bus.done        = r_done;
  assign bus.result      = r_result;
  assign bus.err         = r_err;
  assign bus.ovf         = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_rformat_exec.sv
// =============================================================================
//  Module   : tb_rformat_exec
//  Purpose  : Directed self-checking bench for rformat_exec with a behavioural
//             single-port register file (registered read, one-cycle latency).
//  Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_rformat_exec;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  rformat_exec_if bus ();

  rformat_exec #(.SUPPRESS_R0(1'b1), .OVF_TRAP(1'b1)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Register file model; the bench owns the port while tb_own is set.
  logic [31:0] mem [32];
  logic [31:0] rd_q = 32'd0;
  logic        tb_own = 1'b0;
  logic        tb_we = 1'b0;
  logic [4:0]  tb_addr = 5'd0;
  logic [31:0] tb_wdata = 32'd0;
  int          cyc = 0;
  int          wr_count = 0;
  int          addr_nz = 0;
  int          acc_q[$];

  assign bus.rf_data = rd_q;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (cyc == 0) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'd0;
    end else if (tb_own) begin
      if (tb_we) mem[tb_addr] <= tb_wdata;
      rd_q <= mem[tb_addr];
    end else begin
      if (bus.rf_en_write) begin
        mem[bus.rf_address] <= bus.rf_idata;
        wr_count <= wr_count + 1;
      end
      rd_q <= mem[bus.rf_address];
    end
    if (!tb_own && bus.rf_address != 5'd0) addr_nz <= addr_nz + 1;
    if (bus.in_valid && bus.in_ready) acc_q.push_back(cyc);
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic rf_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clock);
    tb_own = 1'b1; tb_addr = a; tb_wdata = d; tb_we = 1'b1;
    @(negedge clock);
    tb_we = 1'b0; tb_own = 1'b0;
  endtask

  // Counts negedges after the accepting edge until done (0 = timed out).
  task automatic wait_done(output int lat);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      if (bus.done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run(input logic [31:0] ins, output int lat);
    @(negedge clock);
    bus.instr = ins;
    bus.in_valid = 1'b1;
    chk("ready_before_accept", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clock);
    #1 bus.in_valid = 1'b0;
    wait_done(lat);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  localparam logic [31:0] c_RES_EXP [3] = '{32'd180, 32'd0, 32'd244};

  initial begin
    int lat;
    int wc;
    int an;
    int n0;
    logic [31:0] seq [3];

    bus.in_valid = 1'b0;
    bus.instr    = 32'd0;
    seq[0] = 32'h00221822;
    seq[1] = 32'h00221824;
    seq[2] = 32'h00221825;

    // ---- reset state
    #12;
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_we", {31'd0, bus.rf_en_write}, 32'd0);
    chk("rst_addr", {27'd0, bus.rf_address}, 32'd0);
    chk("rst_idata", bus.rf_idata, 32'd0);
    chk("rst_done_err_ovf", {29'd0, bus.done, bus.err, bus.ovf}, 32'd0);
    chk("rst_result", bus.result, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // ---- add
    rf_write(5'd1, 32'd212);
    rf_write(5'd2, 32'd32);
    wc = wr_count;
    run(32'h00221820, lat);
    chk("add_latency", lat, 32'd5);
    chk("add_result", bus.result, 32'd244);
    chk("add_err_ovf", {30'd0, bus.err, bus.ovf}, 32'd0);
    chk("add_r3", mem[3], 32'd244);
    chk("add_writes", wr_count - wc, 32'd1);

    // ---- back-to-back with in_valid held high
    n0 = acc_q.size();
    @(negedge clock);
    bus.instr = seq[0];
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_done(lat);
      chk("b2b_done_seen", {31'd0, (lat != 0)}, 32'd1);
      chk("b2b_result", bus.result, c_RES_EXP[i]);
      chk("b2b_r3", mem[3], c_RES_EXP[i]);
      if (i < 2) bus.instr = seq[i + 1];
      else bus.in_valid = 1'b0;
    end
    @(negedge clock);
    chk("b2b_accepts", acc_q.size() - n0, 32'd3);
    if (acc_q.size() - n0 >= 3) begin
      chk("b2b_gap1", acc_q[n0 + 1] - acc_q[n0], 32'd6);
      chk("b2b_gap2", acc_q[n0 + 2] - acc_q[n0 + 1], 32'd6);
    end

    // ---- compares and arithmetic shift
    rf_write(5'd1, 32'hFFFFFFFB);
    rf_write(5'd2, 32'd3);
    run(32'h0022182A, lat);
    chk("slt_r3", mem[3], 32'd1);
    run(32'h0022182B, lat);
    chk("sltu_r3", mem[3], 32'd0);
    run(32'h00011883, lat);
    chk("sra_r3", mem[3], 32'hFFFFFFFE);
    chk("sra_result", bus.result, 32'hFFFFFFFE);

    // ---- overflow trap then addu
    rf_write(5'd1, 32'h7FFFFFFF);
    rf_write(5'd2, 32'd1);
    wc = wr_count;
    run(32'h00221820, lat);
    chk("ovf_flag", {30'd0, bus.err, bus.ovf}, 32'd1);
    chk("ovf_result", bus.result, 32'h80000000);
    chk("ovf_no_write", wr_count - wc, 32'd0);
    chk("ovf_r3_kept", mem[3], 32'hFFFFFFFE);
    run(32'h00221821, lat);
    chk("addu_r3", mem[3], 32'h80000000);
    chk("addu_ovf", {31'd0, bus.ovf}, 32'd0);

    // ---- illegal opcode / funct, rd=0
    wc = wr_count;
    an = addr_nz;
    run(32'h20220005, lat);
    chk("badop_latency", lat, 32'd1);
    chk("badop_err_ovf", {30'd0, bus.err, bus.ovf}, 32'd2);
    chk("badop_result", bus.result, 32'd0);
    run(32'h00221818, lat);
    chk("badfn_latency", lat, 32'd1);
    chk("badfn_err", {31'd0, bus.err}, 32'd1);
    chk("bad_no_access", addr_nz - an, 32'd0);
    chk("bad_no_write", wr_count - wc, 32'd0);
    rf_write(5'd1, 32'd212);
    rf_write(5'd2, 32'd32);
    wc = wr_count;
    run(32'h00220020, lat);
    chk("rd0_result", bus.result, 32'd244);
    chk("rd0_err_ovf", {30'd0, bus.err, bus.ovf}, 32'd0);
    chk("rd0_no_write", wr_count - wc, 32'd0);

    // ---- reset during WAIT_RT
    rf_write(5'd3, 32'hDEAD0000);
    wc = wr_count;
    @(negedge clock);
    bus.instr = 32'h00221820;
    bus.in_valid = 1'b1;
    @(posedge clock);
    #1 bus.in_valid = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    chk("rstw_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rstw_addr_we", {26'd0, bus.rf_address, bus.rf_en_write}, 32'd0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rstw_ready_after", {31'd0, bus.in_ready}, 32'd1);

    // ---- reset during WRITE
    @(negedge clock);
    bus.instr = 32'h00221820;
    bus.in_valid = 1'b1;
    @(posedge clock);
    #1 bus.in_valid = 1'b0;
    @(posedge clock);
    @(posedge clock);
    @(posedge clock);
    #2;
    chk("write_we_high", {31'd0, bus.rf_en_write}, 32'd1);
    reset = 1'b1;
    #1;
    chk("rstx_we", {31'd0, bus.rf_en_write}, 32'd0);
    chk("rstx_idata", bus.rf_idata, 32'd0);
    chk("rstx_done", {31'd0, bus.done}, 32'd0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rstx_ready_after", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_no_writes", wr_count - wc, 32'd0);
    chk("rst_r3_kept", mem[3], 32'hDEAD0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
